door_access_arbiter: RTL and testbench
======================================

# door_access_arbiter

Round-robin arbiter and sequencer sharing the single `password_in` port of `door_control` among several entry panels: front keypad, rear keypad and remote link. It grants one requester at a time and drives that requester's code for a guaranteed window. It then watches `unlock_signal` / `alarm_signal` to return a pass/fail acknowledge to the winner. While the door is in alarm it refuses all requests.

## Interface
- `NUM_REQ`, 3: number of requesting panels (2..8).
- `PW_W`, 14: password width; matches `door_control`.
- `HOLD_CYCLES`, 2: minimum cycles a granted code is driven (1..15).
- `TIMEOUT`, 8: maximum cycles waited for a result after the hold window (1..255).
- `clk`  in  1  system clock; all flops rise-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  level request per panel; held until `ack` seen.
- `req_password`  in  NUM_REQ*PW_W  code of panel i at bits [i*PW_W +: PW_W].
- `unlock_signal`  in  1  from `door_control`.
- `alarm_signal`  in  1  from `door_control`.
- `password_out`  out  PW_W  to `door_control.password_in`; 0 when idle.
- `grant`  out  NUM_REQ  one-hot owner of the port; all-zero when none.
- `ack`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `ack_ok`  out  1  valid with `ack`; 1 = unlocked, 0 = fail, alarm or timeout.
- `busy`  out  1  high in PRESENT, WAIT, DONE, BLOCKED.

## Operation
- States: IDLE, PRESENT, WAIT, DONE, BLOCKED.
- IDLE:
  - `alarm_signal`=1 -> BLOCKED. This takes precedence over requests.
  - Otherwise, if any `req`: pick the winner by searching from `ptr+1` upward with wrap. Register the one-hot `grant`, latch the winner's code into `pw_reg`, set `ptr` = winner, then go to PRESENT.
- PRESENT:
  - `password_out`=`pw_reg`; hold counter counts HOLD_CYCLES cycles, then go to WAIT with the wait counter cleared.
  - `unlock_signal` or `alarm_signal` is checked here too, with the same effect as in WAIT.
- WAIT:
  - `password_out`=`pw_reg`.
  - `unlock_signal`=1 -> DONE, ok=1.
  - Else `alarm_signal`=1 -> DONE, ok=0, then BLOCKED.
  - Else counter reaches TIMEOUT -> DONE, ok=0.
  - Unlock takes priority over alarm in the same cycle.
- DONE (1 cycle): `grant`=0, `password_out`=0. Pulse `ack[winner]` with `ack_ok`. Next state is BLOCKED if the alarm flag was captured, else IDLE. No arbitration happens in DONE, so the winner has time to drop `req`.
- BLOCKED: `grant`=0, `password_out`=0, `req` ignored. Go to IDLE on the first cycle `alarm_signal`=0.
- Winner drops `req` in PRESENT/WAIT: abort to IDLE with no `ack`. `ptr` stays on that index.
- Code 0 is reserved as the idle value and is never a valid password.
- `req_password` changing after grant has no effect, because the code is latched.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `ptr`=NUM_REQ-1 (req0 wins first), all outputs 0, counters 0.
- `req` sampled high at edge k in IDLE -> `grant` and `password_out` valid from edge k.
- Minimum transaction with an immediate unlock:
  - `unlock_signal` sampled at edge k+1 -> DONE.
  - `ack` high k+2..k+3.
  - Earliest next grant at edge k+3.
- Maximum transaction length: HOLD_CYCLES + TIMEOUT + 2 cycles, measured from the request edge to `ack` deassert.
- `grant` and `password_out` are registered, with no combinational path from inputs.
- `ack` is registered.

## Configuration
- `DOOR_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; lowest index wins.
  - `ptr` is unused and may be removed.
- `DOOR_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
All scenarios use NUM_REQ=3, HOLD_CYCLES=2, TIMEOUT=8.

- **Reset:** pulse `reset` low mid-WAIT with grant=3'b010 -> all outputs 0 immediately; after release, req=3'b111 grants 3'b001.
- **Single request, unlock:** req0 with code 1111; `unlock_signal` high 3 cycles after grant -> `password_out`=1111 for 3 cycles, then `ack`=3'b001 and `ack_ok`=1 for one cycle, then `password_out`=0.
- **Round-robin:** req=3'b111 held, each transaction times out -> grant order 001, 010, 100, 001. Each `ack_ok`=0 after exactly 2+8 cycles of drive.
- **Alarm:** `alarm_signal` rises in WAIT -> `ack_ok`=0 pulse, then BLOCKED. With req=3'b110 held, no grant until `alarm_signal` falls; then 3'b010 is granted the next cycle.
- **Abort:** req1 drops during PRESENT -> no `ack`, grant 0 next cycle. A new req2 then wins.
- **Fixed priority (`DOOR_ARB_FIXED_PRIO_EN`):** req=3'b111 held -> grant is 001 on every transaction.

Source files
------------

// File: rtl/door_access_arbiter.sv
// Shares door_control's password port among NUM_REQ panels with round-robin grant; DOOR_ARB_FIXED_PRIO_EN selects lowest-index-wins.
// Latency: grant/password_out registered on the request edge; ack one cycle after DONE, max HOLD_CYCLES+TIMEOUT+2 cycles.
// Backpressure: req is level-held until ack; all requests are refused while the door is in alarm (BLOCKED).
module door_access_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int PW_W        = 14,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*PW_W-1:0] req_password,
    input  logic                    unlock_signal,
    input  logic                    alarm_signal,
    output logic [PW_W-1:0]         password_out,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    ack_ok,
    output logic                    busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRESENT, S_WAIT, S_DONE, S_BLOCKED} state_t;

    state_t             state;
    logic [3:0]         hold_cnt;
    logic [7:0]         wait_cnt;
    logic [NUM_REQ-1:0] owner;
    logic [PW_W-1:0]    pw_reg;
    logic               ok_flag;
    logic               alarm_flag;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
`ifndef DOOR_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   ptr;
`endif

    // Iterate from the lowest priority down so the last hit is the winner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
`ifdef DOOR_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
`else
        for (int i = NUM_REQ; i >= 1; i--) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
`endif
    end

    assign password_out = pw_reg;
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            wait_cnt   <= '0;
            owner      <= '0;
            pw_reg     <= '0;
            ok_flag    <= 1'b0;
            alarm_flag <= 1'b0;
            grant      <= '0;
            ack        <= '0;
            ack_ok     <= 1'b0;
`ifndef DOOR_ARB_FIXED_PRIO_EN
            ptr        <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            ack    <= '0;
            ack_ok <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (alarm_signal) begin
                        state <= S_BLOCKED;
                    end else if (pick_vld) begin
                        grant      <= NUM_REQ'(1) << pick_idx;
                        owner      <= NUM_REQ'(1) << pick_idx;
                        pw_reg     <= req_password[pick_idx*PW_W +: PW_W];
                        hold_cnt   <= '0;
                        wait_cnt   <= '0;
                        alarm_flag <= 1'b0;
`ifndef DOOR_ARB_FIXED_PRIO_EN
                        ptr        <= pick_idx;
`endif
                        state      <= S_PRESENT;
                    end
                end
                S_PRESENT, S_WAIT: begin
                    if (unlock_signal) begin
                        ok_flag <= 1'b1;
                        grant   <= '0;
                        pw_reg  <= '0;
                        state   <= S_DONE;
                    end else if (alarm_signal) begin
                        ok_flag    <= 1'b0;
                        alarm_flag <= 1'b1;
                        grant      <= '0;
                        pw_reg     <= '0;
                        state      <= S_DONE;
                    end else if ((req & owner) == '0) begin
                        // Winner withdrew: release the port silently.
                        grant  <= '0;
                        pw_reg <= '0;
                        state  <= S_IDLE;
                    end else if (state == S_PRESENT) begin
                        if (hold_cnt == HOLD_LAST) begin
                            wait_cnt <= '0;
                            state    <= S_WAIT;
                        end else begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        ok_flag <= 1'b0;
                        grant   <= '0;
                        pw_reg  <= '0;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    ack    <= owner;
                    ack_ok <= ok_flag;
                    state  <= alarm_flag ? S_BLOCKED : S_IDLE;
                end
                S_BLOCKED: begin
                    if (!alarm_signal) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_door_access_arbiter.sv
// Directed bench for door_access_arbiter (NUM_REQ=3, HOLD_CYCLES=2, TIMEOUT=8).
module tb_door_access_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [41:0] req_password;
    logic        unlock_signal;
    logic        alarm_signal;
    logic [13:0] password_out;
    logic [2:0]  grant;
    logic [2:0]  ack;
    logic        ack_ok;
    logic        busy;

    int total = 0;
    int bad   = 0;

    door_access_arbiter #(
        .NUM_REQ(3), .PW_W(14), .HOLD_CYCLES(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_password(req_password),
        .unlock_signal(unlock_signal), .alarm_signal(alarm_signal),
        .password_out(password_out), .grant(grant), .ack(ack),
        .ack_ok(ack_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [2:0]  rr_grant [4];
    logic [13:0] rr_code  [4];

    initial begin
        // Codes: panel0=1111, panel1=2222, panel2=3333.
        req_password  = {14'd3333, 14'd2222, 14'd1111};
`ifdef DOOR_ARB_FIXED_PRIO_EN
        rr_grant = '{3'b001, 3'b001, 3'b001, 3'b001};
        rr_code  = '{14'd1111, 14'd1111, 14'd1111, 14'd1111};
`else
        rr_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_code  = '{14'd1111, 14'd2222, 14'd3333, 14'd1111};
`endif
        reset = 1'b0; req = '0; unlock_signal = 1'b0; alarm_signal = 1'b0;
        #2;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_pw", 32'(password_out), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        tick(2);
        reset = 1'b1;
        tick(1);

        // Round-robin with every transaction timing out.
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            tick(1);
            chk("rr_grant", 32'(grant), 32'(rr_grant[t]));
            chk("rr_pw_first", 32'(password_out), 32'(rr_code[t]));
            tick(9);
            chk("rr_pw_last", 32'(password_out), 32'(rr_code[t]));
            tick(1);
            chk("rr_pw_off", 32'(password_out), 0);
            chk("rr_grant_off", 32'(grant), 0);
            tick(1);
            chk("rr_ack", 32'(ack), 32'(rr_grant[t]));
            chk("rr_ack_ok", 32'(ack_ok), 0);
            if (t == 3) req = 3'b000;
        end
        tick(1);
        chk("rr_ack_clr", 32'(ack), 0);
        chk("rr_idle", 32'(busy), 0);

        // Single request, unlock sampled on the third edge after grant.
        req = 3'b001;
        tick(1);
        chk("s_grant", 32'(grant), 32'b001);
        chk("s_pw0", 32'(password_out), 1111);
        chk("s_busy", 32'(busy), 1);
        tick(1);
        chk("s_pw1", 32'(password_out), 1111);
        tick(1);
        chk("s_pw2", 32'(password_out), 1111);
        unlock_signal = 1'b1;
        tick(1);
        unlock_signal = 1'b0;
        chk("s_pw_off", 32'(password_out), 0);
        chk("s_grant_off", 32'(grant), 0);
        chk("s_ack_early", 32'(ack), 0);
        tick(1);
        chk("s_ack", 32'(ack), 32'b001);
        chk("s_ack_ok", 32'(ack_ok), 1);
        req = 3'b000;
        tick(1);
        chk("s_ack_clr", 32'(ack), 0);
        chk("s_pw_idle", 32'(password_out), 0);

        // Asynchronous reset in WAIT while panel1 owns the port.
        req = 3'b010;
        tick(1);
        chk("r_grant", 32'(grant), 32'b010);
        tick(3);
        reset = 1'b0;
        #1;
        chk("r_grant0", 32'(grant), 0);
        chk("r_pw0", 32'(password_out), 0);
        chk("r_busy0", 32'(busy), 0);
        tick(1);
        reset = 1'b1;
        req = 3'b111;
        tick(1);
        chk("r_regrant", 32'(grant), 32'b001);
        unlock_signal = 1'b1;
        tick(1);
        unlock_signal = 1'b0;
        req = 3'b000;
        chk("m_grant_off", 32'(grant), 0);
        tick(1);
        chk("m_ack", 32'(ack), 32'b001);
        chk("m_ack_ok", 32'(ack_ok), 1);
        tick(1);
        chk("m_ack_clr", 32'(ack), 0);

        // Alarm during WAIT, then BLOCKED until alarm clears.
        req = 3'b001;
        tick(1);
        chk("a_grant", 32'(grant), 32'b001);
        tick(3);
        alarm_signal = 1'b1;
        tick(1);
        chk("a_grant_off", 32'(grant), 0);
        chk("a_ack_early", 32'(ack), 0);
        tick(1);
        chk("a_ack", 32'(ack), 32'b001);
        chk("a_ack_ok", 32'(ack_ok), 0);
        req = 3'b110;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("a_blocked_grant", 32'(grant), 0);
            chk("a_blocked_busy", 32'(busy), 1);
        end
        alarm_signal = 1'b0;
        tick(1);
        chk("a_release_grant", 32'(grant), 0);
        tick(1);
        chk("a_grant1", 32'(grant), 32'b010);
        chk("a_pw1", 32'(password_out), 2222);

        // Panel1 withdraws during PRESENT; panel2 takes over.
        req = 3'b100;
        tick(1);
        chk("ab_grant_off", 32'(grant), 0);
        chk("ab_no_ack", 32'(ack), 0);
        tick(1);
        chk("ab_grant2", 32'(grant), 32'b100);
        chk("ab_pw2", 32'(password_out), 3333);
        chk("ab_no_ack2", 32'(ack), 0);
        unlock_signal = 1'b1;
        tick(1);
        unlock_signal = 1'b0;
        tick(1);
        chk("ab_ack", 32'(ack), 32'b100);
        chk("ab_ack_ok", 32'(ack_ok), 1);
        req = 3'b000;
        tick(1);

        // Alarm in IDLE outranks a pending request.
        alarm_signal = 1'b1;
        req = 3'b001;
        tick(1);
        chk("ia_grant", 32'(grant), 0);
        chk("ia_busy", 32'(busy), 1);
        alarm_signal = 1'b0;
        req = 3'b000;
        tick(2);
        chk("ia_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
